// File: rtl/writeback_stage_pkg.sv
// Shared types for the writeback stage: FSM states, register-write slot, PC index.
package wb_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 4;

    localparam logic [ADDR_W-1:0] REG_PC = 4'd15;

    typedef enum logic {
        IDLE = 1'b0,
        PEND = 1'b1
    } wb_state_t;

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wb_slot_t;

endpackage

// File: rtl/writeback_stage_if.sv
// Retire-side handshake plus register-file and PC write ports of the writeback stage.
interface writeback_stage_if;
    import wb_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic              in_mem_to_reg;
    logic [DATA_W-1:0] in_alu_result;
    logic [DATA_W-1:0] in_read_data;
    logic              in_res_we;
    logic [ADDR_W-1:0] in_res_addr;
    logic              in_base_we;
    logic [ADDR_W-1:0] in_base_addr;
    logic [DATA_W-1:0] in_base_data;
    logic              we3;
    logic [ADDR_W-1:0] ra3;
    logic [DATA_W-1:0] wd3;
    logic              pc_we;
    logic [DATA_W-1:0] pc_wd;

    modport slave (
        input  in_valid, in_mem_to_reg, in_alu_result, in_read_data,
               in_res_we, in_res_addr, in_base_we, in_base_addr, in_base_data,
        output in_ready, we3, ra3, wd3, pc_we, pc_wd
    );

    modport master (
        output in_valid, in_mem_to_reg, in_alu_result, in_read_data,
               in_res_we, in_res_addr, in_base_we, in_base_addr, in_base_data,
        input  in_ready, we3, ra3, wd3, pc_we, pc_wd
    );

endinterface

// File: rtl/writeback_stage_slot_router.sv
// Steers one write slot to the register-file port or, for R15, to the PC port.
module wb_slot_router
    import wb_pkg::*;
(
    input  wb_slot_t          i_slot,
    output logic              o_we3,
    output logic [ADDR_W-1:0] o_ra3,
    output logic [DATA_W-1:0] o_wd3,
    output logic              o_pc_we,
    output logic [DATA_W-1:0] o_pc_wd
);

    logic w_is_pc;

    always_comb begin
        w_is_pc = (i_slot.addr == REG_PC);
        o_we3   = i_slot.we && !w_is_pc;
        o_pc_we = i_slot.we && w_is_pc;
        o_ra3   = i_slot.addr;
        o_wd3   = i_slot.data;
        o_pc_wd = i_slot.data;
    end

endmodule

// File: rtl/writeback_stage.sv
// Writeback stage: picks the result source, serialises base+result writes onto
// the single register-file port, and diverts R15 writes to the PC port.
//
// state | meaning
// IDLE  | accepting; emits the single write (or BASE of a pair) of the last transfer
// PEND  | stalled; emits the held RES write of a two-write instruction
module writeback_stage
    import wb_pkg::*;
(
    input  logic clk,
    input  logic reset,
    writeback_stage_if.slave bus
);

    wb_state_t         r_state, w_state_next;
    wb_slot_t          r_pend, w_pend_next;
    wb_slot_t          w_emit, w_res, w_base;
    logic              w_fire;

    logic              r_we3, r_pc_we;
    logic [ADDR_W-1:0] r_ra3;
    logic [DATA_W-1:0] r_wd3, r_pc_wd;

    logic              w_we3_n, w_pc_we_n;
    logic [ADDR_W-1:0] w_ra3_n;
    logic [DATA_W-1:0] w_wd3_n, w_pc_wd_n;

    assign bus.in_ready = (r_state == IDLE) && !reset;
    assign w_fire       = bus.in_valid && bus.in_ready;

    // BASE to the same register as RES is dropped so the result always wins.
    always_comb begin
        w_res.we    = bus.in_res_we;
        w_res.addr  = bus.in_res_addr;
        w_res.data  = bus.in_mem_to_reg ? bus.in_read_data : bus.in_alu_result;
        w_base.we   = bus.in_base_we && !(bus.in_res_we && (bus.in_base_addr == bus.in_res_addr));
        w_base.addr = bus.in_base_addr;
        w_base.data = bus.in_base_data;
    end

    always_comb begin
        w_state_next = r_state;
        w_pend_next  = r_pend;
        w_emit       = '0;
        case (r_state)
            IDLE: begin
                if (w_fire) begin
                    if (w_base.we && w_res.we) begin
                        w_emit       = w_base;
                        w_pend_next  = w_res;
                        w_state_next = PEND;
                    end else if (w_base.we) begin
                        w_emit = w_base;
                    end else begin
                        w_emit = w_res;
                    end
                end
            end
            PEND: begin
                w_emit       = r_pend;
                w_pend_next  = '0;
                w_state_next = IDLE;
            end
            default: w_state_next = IDLE;
        endcase
    end

    wb_slot_router u_router (
        .i_slot  (w_emit),
        .o_we3   (w_we3_n),
        .o_ra3   (w_ra3_n),
        .o_wd3   (w_wd3_n),
        .o_pc_we (w_pc_we_n),
        .o_pc_wd (w_pc_wd_n)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_pend  <= '0;
            r_we3   <= 1'b0;
            r_ra3   <= '0;
            r_wd3   <= '0;
            r_pc_we <= 1'b0;
            r_pc_wd <= '0;
        end else begin
            r_state <= w_state_next;
            r_pend  <= w_pend_next;
            r_we3   <= w_we3_n;
            r_pc_we <= w_pc_we_n;
            if (w_we3_n) begin
                r_ra3 <= w_ra3_n;
                r_wd3 <= w_wd3_n;
            end
            if (w_pc_we_n) begin
                r_pc_wd <= w_pc_wd_n;
            end
        end
    end

    assign bus.we3   = r_we3;
    assign bus.ra3   = r_ra3;
    assign bus.wd3   = r_wd3;
    assign bus.pc_we = r_pc_we;
    assign bus.pc_wd = r_pc_wd;

endmodule

// File: tb/tb_writeback_stage.sv
// Directed bench for writeback_stage with hand-computed expected values.
module tb_writeback_stage;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_errors;

    writeback_stage_if bus ();

    writeback_stage dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle_in();
        bus.in_valid      = 1'b0;
        bus.in_mem_to_reg = 1'b0;
        bus.in_alu_result = '0;
        bus.in_read_data  = '0;
        bus.in_res_we     = 1'b0;
        bus.in_res_addr   = '0;
        bus.in_base_we    = 1'b0;
        bus.in_base_addr  = '0;
        bus.in_base_data  = '0;
    endtask

    task automatic drive(input logic m2r, input logic [31:0] alu, input logic [31:0] rd,
                         input logic rwe, input logic [3:0] raddr,
                         input logic bwe, input logic [3:0] baddr, input logic [31:0] bdata);
        bus.in_valid      = 1'b1;
        bus.in_mem_to_reg = m2r;
        bus.in_alu_result = alu;
        bus.in_read_data  = rd;
        bus.in_res_we     = rwe;
        bus.in_res_addr   = raddr;
        bus.in_base_we    = bwe;
        bus.in_base_addr  = baddr;
        bus.in_base_data  = bdata;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        reset    = 1'b1;
        idle_in();

        tick();
        chk("rst_ready_low", {31'd0, bus.in_ready}, 32'd0);
        tick();
        chk("rst_we3", {31'd0, bus.we3}, 32'd0);
        chk("rst_ra3", {28'd0, bus.ra3}, 32'd0);
        chk("rst_wd3", bus.wd3, 32'd0);
        chk("rst_pc_we", {31'd0, bus.pc_we}, 32'd0);
        chk("rst_pc_wd", bus.pc_wd, 32'd0);
        reset = 1'b0;
        #1;
        chk("post_rst_ready", {31'd0, bus.in_ready}, 32'd1);

        // ALU write to R3
        drive(1'b0, 32'h1234, 32'hBEEF, 1'b1, 4'd3, 1'b0, 4'd0, 32'd0);
        tick();
        chk("alu_we3", {31'd0, bus.we3}, 32'd1);
        chk("alu_ra3", {28'd0, bus.ra3}, 32'd3);
        chk("alu_wd3", bus.wd3, 32'h1234);
        chk("alu_pc_we", {31'd0, bus.pc_we}, 32'd0);
        idle_in();
        tick();
        chk("alu_we3_off", {31'd0, bus.we3}, 32'd0);
        chk("alu_ra3_hold", {28'd0, bus.ra3}, 32'd3);
        chk("alu_wd3_hold", bus.wd3, 32'h1234);

        // Load with base writeback, next instruction presented during the stall
        drive(1'b1, 32'hDEAD, 32'hAA, 1'b1, 4'd2, 1'b1, 4'd5, 32'h1004);
        tick();
        chk("ldb_c1_we3", {31'd0, bus.we3}, 32'd1);
        chk("ldb_c1_ra3", {28'd0, bus.ra3}, 32'd5);
        chk("ldb_c1_wd3", bus.wd3, 32'h1004);
        chk("ldb_c1_ready", {31'd0, bus.in_ready}, 32'd0);
        drive(1'b0, 32'h66, 32'h0, 1'b1, 4'd6, 1'b0, 4'd0, 32'd0);
        tick();
        chk("ldb_c2_we3", {31'd0, bus.we3}, 32'd1);
        chk("ldb_c2_ra3", {28'd0, bus.ra3}, 32'd2);
        chk("ldb_c2_wd3", bus.wd3, 32'hAA);
        chk("ldb_c2_ready", {31'd0, bus.in_ready}, 32'd1);
        tick();
        idle_in();
        chk("stall_acc_ra3", {28'd0, bus.ra3}, 32'd6);
        chk("stall_acc_wd3", bus.wd3, 32'h66);
        tick();
        chk("stall_acc_off", {31'd0, bus.we3}, 32'd0);

        // Same address: BASE dropped
        drive(1'b1, 32'h0, 32'h77, 1'b1, 4'd4, 1'b1, 4'd4, 32'h999);
        tick();
        chk("same_ra3", {28'd0, bus.ra3}, 32'd4);
        chk("same_wd3", bus.wd3, 32'h77);
        chk("same_ready", {31'd0, bus.in_ready}, 32'd1);
        idle_in();
        tick();
        chk("same_single", {31'd0, bus.we3}, 32'd0);

        // Result to PC
        drive(1'b0, 32'h200, 32'h0, 1'b1, 4'd15, 1'b0, 4'd0, 32'd0);
        tick();
        chk("pc_pc_we", {31'd0, bus.pc_we}, 32'd1);
        chk("pc_pc_wd", bus.pc_wd, 32'h200);
        chk("pc_we3", {31'd0, bus.we3}, 32'd0);
        chk("pc_ra3_hold", {28'd0, bus.ra3}, 32'd4);
        idle_in();
        tick();
        chk("pc_off", {31'd0, bus.pc_we}, 32'd0);
        chk("pc_wd_hold", bus.pc_wd, 32'h200);

        // Base to PC, result to R1
        drive(1'b0, 32'h11, 32'h0, 1'b1, 4'd1, 1'b1, 4'd15, 32'h300);
        tick();
        chk("bpc_c1_pc_we", {31'd0, bus.pc_we}, 32'd1);
        chk("bpc_c1_pc_wd", bus.pc_wd, 32'h300);
        chk("bpc_c1_we3", {31'd0, bus.we3}, 32'd0);
        idle_in();
        tick();
        chk("bpc_c2_we3", {31'd0, bus.we3}, 32'd1);
        chk("bpc_c2_ra3", {28'd0, bus.ra3}, 32'd1);
        chk("bpc_c2_wd3", bus.wd3, 32'h11);
        chk("bpc_c2_pc_we", {31'd0, bus.pc_we}, 32'd0);

        // No slot enabled: accepted, nothing written
        drive(1'b0, 32'h55, 32'h0, 1'b0, 4'd9, 1'b0, 4'd10, 32'h1);
        tick();
        chk("none_we3", {31'd0, bus.we3}, 32'd0);
        chk("none_pc_we", {31'd0, bus.pc_we}, 32'd0);
        chk("none_ready", {31'd0, bus.in_ready}, 32'd1);

        // Reset while PEND: held RES discarded
        drive(1'b1, 32'h0, 32'h80, 1'b1, 4'd8, 1'b1, 4'd7, 32'h70);
        tick();
        chk("rp_c1_ra3", {28'd0, bus.ra3}, 32'd7);
        idle_in();
        reset = 1'b1;
        #1;
        chk("rp_ready_rst", {31'd0, bus.in_ready}, 32'd0);
        tick();
        chk("rp_we3", {31'd0, bus.we3}, 32'd0);
        chk("rp_ra3", {28'd0, bus.ra3}, 32'd0);
        chk("rp_wd3", bus.wd3, 32'd0);
        reset = 1'b0;
        #1;
        chk("rp_ready_after", {31'd0, bus.in_ready}, 32'd1);
        tick();
        chk("rp_no_res_we3", {31'd0, bus.we3}, 32'd0);
        chk("rp_no_res_ra3", {28'd0, bus.ra3}, 32'd0);

        // Reset during a transfer cycle: no transfer
        reset = 1'b1;
        drive(1'b0, 32'h99, 32'h0, 1'b1, 4'd9, 1'b0, 4'd0, 32'd0);
        tick();
        reset = 1'b0;
        idle_in();
        tick();
        chk("rt_we3", {31'd0, bus.we3}, 32'd0);
        chk("rt_ra3", {28'd0, bus.ra3}, 32'd0);

        // Back-to-back single writes
        for (int i = 0; i < 8; i++) begin
            drive(1'b0, 32'h100 + i, 32'h0, 1'b1, i[3:0], 1'b0, 4'd0, 32'd0);
            chk("b2b_ready", {31'd0, bus.in_ready}, 32'd1);
            tick();
            chk("b2b_we3", {31'd0, bus.we3}, 32'd1);
            chk("b2b_ra3", {28'd0, bus.ra3}, i);
            chk("b2b_wd3", bus.wd3, 32'h100 + i);
        end
        idle_in();
        tick();
        chk("b2b_end", {31'd0, bus.we3}, 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/writeback_stage.md
# writeback_stage

Final pipeline stage that consumes retired-instruction results and drives the register file's single write port (`we3`, `ra3`, `wd3`). Selects the load or ALU result, serializes instructions that retire two register updates (load/store with base writeback) onto the one port, and diverts any write to R15 to a PC-write port, because the register file stores only R0–R14. Upstream sees a valid/ready handshake; downstream sees at most one register write and one PC write per cycle.

## Interface
- `DATA_W`, 32: datapath width.
- `ADDR_W`, 4: register address width; address `2**ADDR_W-1` (15) is the PC.

- `clk`  in  1  rising-edge clock.
- `reset`  in  1  synchronous, active-high.
- `in_valid`  in  1  upstream has a retiring instruction.
- `in_ready`  out  1  stage can accept this cycle.
- `in_mem_to_reg`  in  1  result source: 1 = `in_read_data`, 0 = `in_alu_result`.
- `in_alu_result`  in  DATA_W  ALU result.
- `in_read_data`  in  DATA_W  memory load data.
- `in_res_we`  in  1  result write enable.
- `in_res_addr`  in  ADDR_W  result destination.
- `in_base_we`  in  1  base-register writeback enable.
- `in_base_addr`  in  ADDR_W  base register.
- `in_base_data`  in  DATA_W  updated base value.
- `we3`  out  1  register-file write enable.
- `ra3`  out  ADDR_W  register-file write address.
- `wd3`  out  DATA_W  register-file write data.
- `pc_we`  out  1  PC write pulse.
- `pc_wd`  out  DATA_W  PC write data.

## Operation
- Transfer occurs on a rising edge where `in_valid && in_ready`.
- `res_data = in_mem_to_reg ? in_read_data : in_alu_result`, captured at the transfer.
- Write slots: BASE (`in_base_*`) and RES (`in_res_*`, `res_data`). Slots with enable 0 are dropped.
- Both enabled with the same address: BASE is dropped. The instruction is treated as RES-only.
- Both enabled with different addresses: BASE is emitted first, then RES. The load result is always the last write.
- Routing per emitted slot: if address == 15, drive `pc_we=1`, `pc_wd=data`, `we3=0`. Otherwise drive `we3=1`, `ra3=addr`, `wd3=data`, `pc_we=0`.
- Neither slot enabled: the transfer is accepted and no write is emitted.
- FSM, 2 states:
  - IDLE: `in_ready=1`.
    - On transfer with two distinct slots: emit BASE, latch RES, go to PEND.
    - On transfer with one slot: emit it, stay in IDLE.
    - No transfer: emitted outputs go idle (`we3=0`, `pc_we=0`).
  - PEND: `in_ready=0`, `in_valid` ignored. Emit the held RES, return to IDLE.
- While `we3=0`, `ra3` and `wd3` hold their last values. While `pc_we=0`, `pc_wd` holds its last value.

## Timing
- All outputs come from registers, except `in_ready`, which is combinational from state and `reset`.
- Latency: a transfer at edge N drives outputs during cycle N+1, so the register file commits at edge N+1.
- A second write drives outputs during cycle N+2 and commits at edge N+2. `in_ready` is low throughout cycle N+1.
- Throughput: one single-write instruction per cycle; a two-write instruction occupies two cycles.
- Reset, sampled at an edge, sets:
  - state to IDLE;
  - `we3=0`, `ra3=0`, `wd3=0`, `pc_we=0`, `pc_wd=0`.
- `in_ready=0` while `reset` is high.
- Reset in PEND: the held RES write is discarded and never emitted.
- Reset during a transfer cycle: the transfer does not occur.
- `we3` and `pc_we` are never both 1 in the same cycle.

## Structure
- Package `wb_pkg` contains:
  - `wb_state_t` enum {IDLE, PEND};
  - constant `REG_PC = 4'd15`;
  - packed struct `wb_slot_t` {we, addr, data}.
- One sub-module, `wb_slot_router`: combinational. Maps a `wb_slot_t` to {`we3`, `ra3`, `wd3`, `pc_we`, `pc_wd`} next values, handling the R15 diversion. The top level holds the FSM, the pending-slot register and the output registers.

## Test plan
- ALU write: `in_res_we=1`, `addr=3`, `alu=0x1234`, `mem_to_reg=0` -> next cycle `we3=1`, `ra3=3`, `wd3=0x1234`; following cycle `we3=0`.
- Load with base writeback: `res_addr=2`, `read_data=0xAA`, `base_addr=5`, `base_data=0x1004` -> cycle 1 (`ra3=5`, `wd3=0x1004`), cycle 2 (`ra3=2`, `wd3=0xAA`); `in_ready=0` in cycle 1; a `valid` presented in cycle 1 is accepted only in cycle 2.
- Same address: `res_addr=base_addr=4`, `read_data=0x77` -> a single write (`ra3=4`, `wd3=0x77`); `in_ready` stays 1.
- PC destination: `res_addr=15`, `alu=0x200` -> `pc_we=1`, `pc_wd=0x200`, `we3=0`. With `base_addr=15` and `res_addr=1`: cycle 1 `pc_we=1`, cycle 2 `we3=1` with `ra3=1`.
- Reset in PEND: assert `reset` the cycle after a two-write transfer -> the RES write never appears. All outputs are 0 the cycle after reset. `in_ready=0` while reset is high and 1 afterwards.
- Back-to-back single writes for 8 cycles with addresses 0..7 -> 8 consecutive `we3` pulses in order, `in_ready` constantly 1.
